// File: rtl/encoder_4to2_seq_if.sv
// Handshake bundle between a request source/consumer and encoder_4to2_seq.
// The master side supplies the request vector, load strobe and ready; the
// slave side (the encoder) returns the index, valid and status flags.
interface encoder_4to2_seq_if;
    logic [3:0] D;
    logic       E;
    logic       ready;
    logic [1:0] A;
    logic       V;
    logic       busy;
    logic       multi;

    modport master (
        output D, E, ready,
        input  A, V, busy, multi
    );

    modport slave (
        input  D, E, ready,
        output A, V, busy, multi
    );
endinterface

// File: rtl/encoder_4to2_seq.sv
// Sequential 4-to-2 priority encoder. Captures a request vector on an accepted
// load and emits the index of every set bit, highest first, one per handshake.
// A and V come straight from registered state, so they only change after clk.
module encoder_4to2_seq (
    input  logic                     clk,
    input  logic                     rst_n,
    encoder_4to2_seq_if.slave        bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] pending_q, pending_d;
    logic       multi_q, multi_d;
    logic [1:0] idx;
    logic       load_req;
    logic       take;

    // Highest set pending bit wins; index 0 when nothing is pending.
    always_comb begin
        idx = 2'd0;
        if (pending_q[3])      idx = 2'd3;
        else if (pending_q[2]) idx = 2'd2;
        else if (pending_q[1]) idx = 2'd1;
        else                   idx = 2'd0;
    end

    assign load_req = bus.E && (bus.D != 4'b0000);
    assign take     = (state_q == DRAIN) && bus.ready;

    // Next-state: load only from IDLE, otherwise retire one bit per handshake.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        multi_d   = multi_q;
        case (state_q)
            IDLE: begin
                if (load_req) begin
                    pending_d = bus.D;
                    // More than one bit set iff clearing the lowest leaves something.
                    multi_d   = ((bus.D & (bus.D - 4'd1)) != 4'b0000);
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                if (take) begin
                    pending_d = pending_q & ~(4'b0001 << idx);
                    if ((pending_q & ~(4'b0001 << idx)) == 4'b0000)
                        state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = 4'b0000;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 4'b0000;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            multi_q   <= multi_d;
        end
    end

    assign bus.V     = (state_q == DRAIN);
    assign bus.busy  = (state_q == DRAIN);
    assign bus.A     = (state_q == DRAIN) ? idx : 2'd0;
    assign bus.multi = multi_q;

endmodule

// File: tb/tb_encoder_4to2_seq.sv
// Directed bench for encoder_4to2_seq. Inputs change and outputs are sampled
// on the falling edge; a tiny 2-to-4 decoder model checks the round trip.
module tb_encoder_4to2_seq;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    encoder_4to2_seq_if bus ();

    encoder_4to2_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] dec2to4(input logic [1:0] a, input logic e);
        dec2to4 = e ? (4'b0001 << a) : 4'b0000;
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Check A, V, busy, multi in one call.
    task automatic chk_out(input string tag, input logic [1:0] a, input logic v, input logic m);
        chk({tag, ".A"},     {2'b00, bus.A}, {2'b00, a});
        chk({tag, ".V"},     {3'b000, bus.V}, {3'b000, v});
        chk({tag, ".busy"},  {3'b000, bus.busy}, {3'b000, v});
        chk({tag, ".multi"}, {3'b000, bus.multi}, {3'b000, m});
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n     = 1'b0;
        bus.D     = 4'b0000;
        bus.E     = 1'b0;
        bus.ready = 1'b0;
        @(negedge clk);
        tick();
        chk_out("reset", 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Single bit
        bus.D = 4'b0100; bus.E = 1'b1; bus.ready = 1'b1;
        tick();
        chk_out("single.ld", 2'd2, 1'b1, 1'b0);
        bus.E = 1'b0;
        tick();
        chk_out("single.done", 2'd0, 1'b0, 1'b0);

        // Full drain order plus decoder round trip
        bus.D = 4'b1011; bus.E = 1'b1;
        tick();
        chk_out("drain.3", 2'd3, 1'b1, 1'b1);
        chk("rt.Y3", dec2to4(bus.A, bus.V), 4'b1000);
        bus.E = 1'b0;
        tick();
        chk_out("drain.1", 2'd1, 1'b1, 1'b1);
        chk("rt.Y1", dec2to4(bus.A, bus.V), 4'b0010);
        tick();
        chk_out("drain.0", 2'd0, 1'b1, 1'b1);
        chk("rt.Y0", dec2to4(bus.A, bus.V), 4'b0001);
        tick();
        chk_out("drain.end", 2'd0, 1'b0, 1'b1);
        chk("rt.Yidle", dec2to4(bus.A, bus.V), 4'b0000);

        // Backpressure
        bus.ready = 1'b0;
        bus.D = 4'b0110; bus.E = 1'b1;
        tick();
        chk_out("bp.ld", 2'd2, 1'b1, 1'b1);
        bus.E = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("bp.hold", 2'd2, 1'b1, 1'b1);
        end
        bus.ready = 1'b1;
        tick();
        chk_out("bp.1", 2'd1, 1'b1, 1'b1);
        tick();
        chk_out("bp.end", 2'd0, 1'b0, 1'b1);

        // Load during drain and on the final handshake is ignored
        bus.D = 4'b0011; bus.E = 1'b1;
        tick();
        chk_out("ign.ld", 2'd1, 1'b1, 1'b1);
        bus.D = 4'b1000;
        tick();
        chk_out("ign.0", 2'd0, 1'b1, 1'b1);
        tick();
        chk_out("ign.last", 2'd0, 1'b0, 1'b1);
        bus.E = 1'b0;
        tick();
        chk_out("ign.idle", 2'd0, 1'b0, 1'b1);

        // E with D=0 in IDLE: no load, multi unchanged
        bus.D = 4'b0000; bus.E = 1'b1;
        tick();
        chk_out("zero.ld", 2'd0, 1'b0, 1'b1);
        bus.E = 1'b0;

        // Reset mid-drain
        bus.D = 4'b1111; bus.E = 1'b1;
        tick();
        chk_out("rst.ld", 2'd3, 1'b1, 1'b1);
        bus.E = 1'b0;
        tick();
        chk_out("rst.2", 2'd2, 1'b1, 1'b1);
        rst_n = 1'b0;
        tick();
        chk_out("rst.mid", 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk_out("rst.hold", 2'd0, 1'b0, 1'b0);
        bus.D = 4'b0001; bus.E = 1'b1;
        tick();
        chk_out("rst.reload", 2'd0, 1'b1, 1'b0);
        chk("rt.Yb0", dec2to4(bus.A, bus.V), 4'b0001);
        bus.E = 1'b0;
        tick();
        chk_out("rst.end", 2'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
